// File: rtl/matmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : matmul_pkg
// Brief    : Shared state encoding and default dimensions for matmul_seq_ctrl.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package matmul_pkg;

   localparam int c_def_m         = 3;
   localparam int c_def_n         = 3;
   localparam int c_def_p         = 3;
   localparam int c_def_aw        = 8;
   localparam int c_def_out_beats = 3;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD_A = 4'd1,
      S_LOAD_B = 4'd2,
      S_RD_C   = 4'd3,
      S_INIT   = 4'd4,
      S_RD_AB  = 4'd5,
      S_MAC    = 4'd6,
      S_WR_C   = 4'd7,
      S_OUT_RD = 4'd8,
      S_OUT_SH = 4'd9,
      S_FIN    = 4'd10
   } state_t;

   // Beat index width, never narrower than one bit.
   function automatic int beat_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idx_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : idx_gen
// Brief    : Load/output word counter and i/j/k loop indices with wrap logic.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module idx_gen #(
   parameter int M  = 3,
   parameter int N  = 3,
   parameter int P  = 3,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_job_clr,
   input  logic          i_ld_inc,
   input  logic          i_ld_clr,
   input  logic          i_k_step,
   input  logic          i_ij_step,
   output logic [AW-1:0] o_ld_cnt,
   output logic [AW-1:0] o_i,
   output logic [AW-1:0] o_j,
   output logic [AW-1:0] o_k,
   output logic          o_k_last,
   output logic          o_j_last,
   output logic          o_i_last
);

   localparam logic [AW-1:0] c_one  = AW'(1);
   localparam logic [AW-1:0] c_m_m1 = AW'(M - 1);
   localparam logic [AW-1:0] c_n_m1 = AW'(N - 1);
   localparam logic [AW-1:0] c_p_m1 = AW'(P - 1);

   logic [AW-1:0] r_ld;
   logic [AW-1:0] r_i;
   logic [AW-1:0] r_j;
   logic [AW-1:0] r_k;

   assign o_ld_cnt = r_ld;
   assign o_i      = r_i;
   assign o_j      = r_j;
   assign o_k      = r_k;
   assign o_k_last = (r_k == c_n_m1);
   assign o_j_last = (r_j == c_p_m1);
   assign o_i_last = (r_i == c_m_m1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ld <= '0;
         r_i  <= '0;
         r_j  <= '0;
         r_k  <= '0;
      end else if (i_job_clr) begin
         r_ld <= '0;
         r_i  <= '0;
         r_j  <= '0;
         r_k  <= '0;
      end else begin
         // Clear wins over increment so the terminal word leaves the counter at 0.
         if (i_ld_clr)
            r_ld <= '0;
         else if (i_ld_inc)
            r_ld <= r_ld + c_one;

         if (i_k_step)
            r_k <= o_k_last ? '0 : r_k + c_one;

         if (i_ij_step) begin
            if (o_j_last) begin
               r_j <= '0;
               r_i <= o_i_last ? '0 : r_i + c_one;
            end else begin
               r_j <= r_j + c_one;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : matmul_seq_ctrl
// Brief    : Sequencer for load / multiply-accumulate / stream-out of C = A*B.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int M         = c_def_m,
   parameter int N         = c_def_n,
   parameter int P         = c_def_p,
   parameter int AW        = c_def_aw,
   parameter int OUT_BEATS = c_def_out_beats
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          acc_mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          mA_en,
   output logic                          mA_we,
   output logic [AW-1:0]                 mA_addr,
   output logic                          mB_en,
   output logic                          mB_we,
   output logic [AW-1:0]                 mB_addr,
   output logic                          mC_en,
   output logic                          mC_we,
   output logic [AW-1:0]                 mC_addr,
   output logic                          mac_ld,
   output logic                          mac_clr,
   output logic                          mac_init,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [beat_w(OUT_BEATS)-1:0]  out_beat,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done
);

   localparam int               c_bw        = beat_w(OUT_BEATS);
   localparam logic [AW-1:0]    c_n         = AW'(N);
   localparam logic [AW-1:0]    c_p         = AW'(P);
   localparam logic [AW-1:0]    c_mn_last   = AW'(M * N - 1);
   localparam logic [AW-1:0]    c_np_last   = AW'(N * P - 1);
   localparam logic [AW-1:0]    c_mp_last   = AW'(M * P - 1);
   localparam logic [c_bw-1:0]  c_beat_last = c_bw'(OUT_BEATS - 1);
   localparam logic [c_bw-1:0]  c_beat_one  = c_bw'(1);

   state_t          r_state;
   logic            r_mode;
   logic [c_bw-1:0] r_beat;

   logic [AW-1:0] w_ld, w_i, w_j, w_k;
   logic          w_k_last, w_j_last, w_i_last;
   logic          w_job_clr, w_ld_inc, w_ld_clr, w_k_step, w_ij_step;
   logic [AW-1:0] w_ij_addr, w_a_addr, w_b_addr;
   logic          w_beat_last, w_word_last;

   idx_gen #(.M(M), .N(N), .P(P), .AW(AW)) u_idx_gen (
      .clk       (clk),
      .rst       (rst),
      .i_job_clr (w_job_clr),
      .i_ld_inc  (w_ld_inc),
      .i_ld_clr  (w_ld_clr),
      .i_k_step  (w_k_step),
      .i_ij_step (w_ij_step),
      .o_ld_cnt  (w_ld),
      .o_i       (w_i),
      .o_j       (w_j),
      .o_k       (w_k),
      .o_k_last  (w_k_last),
      .o_j_last  (w_j_last),
      .o_i_last  (w_i_last)
   );

   // Products stay below 2^AW because every matrix fits in its AW-bit space.
   assign w_ij_addr   = w_i * c_p + w_j;
   assign w_a_addr    = w_i * c_n + w_k;
   assign w_b_addr    = w_k * c_p + w_j;
   assign w_beat_last = (r_beat == c_beat_last);
   assign w_word_last = (w_ld == c_mp_last);

   assign busy     = (r_state != S_IDLE);
   assign out_beat = r_beat;

   always_comb begin
      in_ready  = 1'b0;
      mA_en     = 1'b0;
      mA_we     = 1'b0;
      mA_addr   = '0;
      mB_en     = 1'b0;
      mB_we     = 1'b0;
      mB_addr   = '0;
      mC_en     = 1'b0;
      mC_we     = 1'b0;
      mC_addr   = '0;
      mac_ld    = 1'b0;
      mac_clr   = 1'b0;
      mac_init  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      w_job_clr = 1'b0;
      w_ld_inc  = 1'b0;
      w_ld_clr  = 1'b0;
      w_k_step  = 1'b0;
      w_ij_step = 1'b0;
      case (r_state)
         S_IDLE: w_job_clr = start;
         S_LOAD_A: begin
            in_ready = 1'b1;
            mA_en    = in_valid;
            mA_we    = in_valid;
            mA_addr  = w_ld;
            w_ld_inc = in_valid;
            w_ld_clr = in_valid && (w_ld == c_mn_last);
         end
         S_LOAD_B: begin
            in_ready = 1'b1;
            mB_en    = in_valid;
            mB_we    = in_valid;
            mB_addr  = w_ld;
            w_ld_inc = in_valid;
            w_ld_clr = in_valid && (w_ld == c_np_last);
         end
         S_RD_C: begin
            mC_en   = 1'b1;
            mC_addr = w_ij_addr;
         end
         S_INIT: mac_init = 1'b1;
         S_RD_AB: begin
            mA_en   = 1'b1;
            mB_en   = 1'b1;
            mA_addr = w_a_addr;
            mB_addr = w_b_addr;
         end
         S_MAC: begin
            mac_ld   = 1'b1;
            w_k_step = 1'b1;
         end
         S_WR_C: begin
            mC_en     = 1'b1;
            mC_we     = 1'b1;
            mC_addr   = w_ij_addr;
            mac_clr   = 1'b1;
            w_ij_step = 1'b1;
         end
         S_OUT_RD: begin
            mC_en   = 1'b1;
            mC_addr = w_ld;
         end
         S_OUT_SH: begin
            out_valid = 1'b1;
            out_last  = w_beat_last && w_word_last;
            w_ld_inc  = out_ready && w_beat_last && !w_word_last;
            w_ld_clr  = out_ready && w_beat_last && w_word_last;
         end
         S_FIN: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode  <= acc_mode;
                  r_state <= S_LOAD_A;
               end
            end
            S_LOAD_A: if (w_ld_clr) r_state <= S_LOAD_B;
            S_LOAD_B: if (w_ld_clr) r_state <= r_mode ? S_RD_C : S_RD_AB;
            S_RD_C:   r_state <= S_INIT;
            S_INIT:   r_state <= S_RD_AB;
            S_RD_AB:  r_state <= S_MAC;
            S_MAC:    r_state <= w_k_last ? S_WR_C : S_RD_AB;
            S_WR_C: begin
               if (w_i_last && w_j_last)
                  r_state <= S_OUT_RD;
               else
                  r_state <= r_mode ? S_RD_C : S_RD_AB;
            end
            S_OUT_RD: begin
               r_beat  <= '0;
               r_state <= S_OUT_SH;
            end
            S_OUT_SH: begin
               if (out_ready) begin
                  if (w_beat_last) begin
                     r_beat  <= '0;
                     r_state <= w_word_last ? S_FIN : S_OUT_RD;
                  end else begin
                     r_beat <= r_beat + c_beat_one;
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_matmul_seq_ctrl
// Brief    : Bench with memory/MAC model and a beat scoreboard for matmul_seq_ctrl.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

   localparam int AW = 8;

   typedef struct packed {
      int   word;
      int   beat;
      logic last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start = 1'b0, acc_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, mA_en, mA_we, mB_en, mB_we, mC_en, mC_we;
   logic [AW-1:0] mA_addr, mB_addr, mC_addr;
   logic          mac_ld, mac_clr, mac_init, out_valid, out_last, busy, done;
   logic [1:0]    out_beat;
   logic [39:0]   all_out;

   assign all_out = {in_ready, mA_en, mA_we, mA_addr, mB_en, mB_we, mB_addr,
                     mC_en, mC_we, mC_addr, mac_ld, mac_clr, mac_init,
                     out_valid, out_beat, out_last, busy, done};

   matmul_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
      .in_valid(in_valid), .in_ready(in_ready),
      .mA_en(mA_en), .mA_we(mA_we), .mA_addr(mA_addr),
      .mB_en(mB_en), .mB_we(mB_we), .mB_addr(mB_addr),
      .mC_en(mC_en), .mC_we(mC_we), .mC_addr(mC_addr),
      .mac_ld(mac_ld), .mac_clr(mac_clr), .mac_init(mac_init),
      .out_valid(out_valid), .out_ready(out_ready), .out_beat(out_beat),
      .out_last(out_last), .busy(busy), .done(done)
   );

   logic          d2_start = 1'b0, d2_in_valid = 1'b0, d2_out_ready = 1'b0;
   logic          d2_in_ready, d2_mA_en, d2_mA_we, d2_mB_en, d2_mB_we, d2_mC_en, d2_mC_we;
   logic [AW-1:0] d2_mA_addr, d2_mB_addr, d2_mC_addr;
   logic          d2_mac_ld, d2_mac_clr, d2_mac_init, d2_out_valid, d2_out_last, d2_busy, d2_done;
   logic [1:0]    d2_out_beat;

   matmul_seq_ctrl #(.M(2), .N(4), .P(3)) dut2 (
      .clk(clk), .rst(rst), .start(d2_start), .acc_mode(1'b0),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .mA_en(d2_mA_en), .mA_we(d2_mA_we), .mA_addr(d2_mA_addr),
      .mB_en(d2_mB_en), .mB_we(d2_mB_we), .mB_addr(d2_mB_addr),
      .mC_en(d2_mC_en), .mC_we(d2_mC_we), .mC_addr(d2_mC_addr),
      .mac_ld(d2_mac_ld), .mac_clr(d2_mac_clr), .mac_init(d2_mac_init),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_beat(d2_out_beat),
      .out_last(d2_out_last), .busy(d2_busy), .done(d2_done)
   );

   // Memories with one-cycle read latency and the MAC accumulator.
   int   memA [256];
   int   memB [256];
   int   memC [256];
   int   rdA, rdB, rdC, acc;
   int   in_data = 0;
   logic preload = 1'b0;
   int   c_pre [9];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= 0;
      end else begin
         if (preload)
            for (int w = 0; w < 9; w++) memC[w] <= c_pre[w];
         if (mA_en && mA_we)  memA[mA_addr] <= in_data;
         if (mA_en && !mA_we) rdA <= memA[mA_addr];
         if (mB_en && mB_we)  memB[mB_addr] <= in_data;
         if (mB_en && !mB_we) rdB <= memB[mB_addr];
         if (mC_en && mC_we)  memC[mC_addr] <= acc;
         if (mC_en && !mC_we) rdC <= memC[mC_addr];
         if (mac_clr)       acc <= 0;
         else if (mac_init) acc <= rdC;
         else if (mac_ld)   acc <= acc + rdA * rdB;
      end
   end

   int    n_cmp = 0;
   int    n_mis = 0;
   beat_t exp_q [$];
   int    a_vals [9];
   int    b_vals [9];
   int    g_compute, g_inits, g_done, g_beats, g_hold_err;

   task automatic push_expected(input bit mode);
      beat_t e;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            int s;
            s = mode ? c_pre[i*3+j] : 0;
            for (int k = 0; k < 3; k++) s += a_vals[i*3+k] * b_vals[k*3+j];
            for (int b = 0; b < 3; b++) begin
               e.word = s;
               e.beat = b;
               e.last = (i == 2 && j == 2 && b == 2);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic load_job(input bit mode, input bit stall, input bit poke);
      int idx = 0;
      int cyc = 0;
      bit acc_now;
      @(negedge clk);
      if (mode) begin
         preload = 1'b1;
         @(negedge clk);
         preload = 1'b0;
      end
      start = 1'b1;
      acc_mode = mode;
      @(negedge clk);
      start = 1'b0;
      acc_mode = 1'b0;
      while (idx < 18 && cyc < 2000) begin
         in_valid = stall ? (cyc % 2 == 0) : 1'b1;
         in_data  = (idx < 9) ? a_vals[idx] : b_vals[idx-9];
         start    = poke && (idx == 12);
         acc_now  = in_valid && in_ready;
         @(negedge clk);
         if (acc_now) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_job(input bit hold, input bit poke);
      int         cyc = 0;
      int         hold_cnt = 0;
      bit         held = 1'b0;
      logic [1:0] frozen = '0;
      beat_t      o, e;
      g_compute = 0; g_inits = 0; g_done = 0; g_beats = 0; g_hold_err = 0;
      while (!out_valid && cyc < 5000) begin
         g_compute++;
         if (mac_init) g_inits++;
         @(negedge clk);
         cyc++;
      end
      g_compute--;  // the OUT_RD cycle precedes the first valid beat
      while (cyc < 5000) begin
         if (done) g_done++;
         if (g_done > 0 && !done) break;
         if (hold && !held && g_beats == 13) begin
            held = 1'b1;
            hold_cnt = 4;
            frozen = out_beat;
         end
         if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
            if (out_beat !== frozen) g_hold_err++;
         end else begin
            out_ready = 1'b1;
         end
         start = poke && (g_beats == 5);
         if (out_valid && out_ready) begin
            o.word = rdC;
            o.beat = int'(out_beat);
            o.last = out_last;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_mis++;
               $display("FAIL extra_beat %0d: got word=%0d beat=%0d, required none", g_beats, o.word, o.beat);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  n_mis++;
                  $display("FAIL beat %0d: got word=%0d beat=%0d last=%0b, required word=%0d beat=%0d last=%0b",
                           g_beats, o.word, o.beat, o.last, e.word, e.beat, e.last);
               end
            end
            g_beats++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      start = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL beats_missing: got %0d left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (all_out !== '0) begin
         n_mis++;
         $display("FAIL reset_outputs: got %h, required 0", all_out);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (all_out !== '0) begin
         n_mis++;
         $display("FAIL idle_outputs: got %h, required 0", all_out);
      end
   endtask

   task automatic test_basic;
      for (int w = 0; w < 9; w++) begin
         a_vals[w] = w + 1;
         b_vals[w] = (w % 4 == 0) ? 1 : 0;
      end
      push_expected(1'b0);
      load_job(1'b0, 1'b0, 1'b0);
      finish_job(1'b0, 1'b0);
      n_cmp++;
      if (g_compute != 63) begin n_mis++; $display("FAIL basic_compute: got %0d, required 63", g_compute); end
      n_cmp++;
      if (g_beats != 27) begin n_mis++; $display("FAIL basic_beats: got %0d, required 27", g_beats); end
      n_cmp++;
      if (g_done != 1) begin n_mis++; $display("FAIL basic_done: got %0d cycles, required 1", g_done); end
   endtask

   task automatic test_accumulate;
      for (int w = 0; w < 9; w++) begin
         a_vals[w] = (w % 4 == 0) ? 1 : 0;
         b_vals[w] = (w % 4 == 0) ? 1 : 0;
         c_pre[w]  = 5;
      end
      push_expected(1'b1);
      load_job(1'b1, 1'b0, 1'b0);
      finish_job(1'b0, 1'b0);
      n_cmp++;
      if (g_inits != 9) begin n_mis++; $display("FAIL acc_inits: got %0d, required 9", g_inits); end
      n_cmp++;
      if (g_compute != 81) begin n_mis++; $display("FAIL acc_compute: got %0d, required 81", g_compute); end
      n_cmp++;
      if (g_done != 1) begin n_mis++; $display("FAIL acc_done: got %0d cycles, required 1", g_done); end
   endtask

   task automatic test_stall_hold;
      for (int w = 0; w < 9; w++) begin
         a_vals[w] = int'($urandom_range(0, 15));
         b_vals[w] = int'($urandom_range(0, 15));
      end
      push_expected(1'b0);
      load_job(1'b0, 1'b1, 1'b0);
      finish_job(1'b1, 1'b0);
      n_cmp++;
      if (g_hold_err != 0) begin n_mis++; $display("FAIL hold_beat_frozen: got %0d moves, required 0", g_hold_err); end
      n_cmp++;
      if (g_beats != 27) begin n_mis++; $display("FAIL stall_beats: got %0d, required 27", g_beats); end
      n_cmp++;
      if (g_compute != 63) begin n_mis++; $display("FAIL stall_compute: got %0d, required 63", g_compute); end
   endtask

   task automatic test_start_ignored;
      for (int w = 0; w < 9; w++) begin
         a_vals[w] = int'($urandom_range(0, 9));
         b_vals[w] = int'($urandom_range(0, 9));
         c_pre[w]  = int'($urandom_range(0, 20));
      end
      push_expected(1'b1);
      load_job(1'b1, 1'b0, 1'b1);
      finish_job(1'b0, 1'b1);
      n_cmp++;
      if (g_compute != 81) begin n_mis++; $display("FAIL poke_compute: got %0d, required 81", g_compute); end
      n_cmp++;
      if (g_done != 1) begin n_mis++; $display("FAIL poke_done: got %0d cycles, required 1", g_done); end
   endtask

   task automatic test_reset_mid;
      int nwr = 0;
      int cyc = 0;
      bit hit = 1'b0;
      for (int w = 0; w < 9; w++) begin
         a_vals[w] = int'($urandom_range(1, 12));
         b_vals[w] = int'($urandom_range(1, 12));
      end
      load_job(1'b0, 1'b0, 1'b0);
      while (cyc < 2000 && !hit) begin
         if (mac_ld && nwr == 5) begin
            hit = 1'b1;
         end else begin
            if (mC_we) nwr++;
            @(negedge clk);
            cyc++;
         end
      end
      n_cmp++;
      if (!hit) begin n_mis++; $display("FAIL reset_mid_reach: got no MAC of (1,2), required one"); end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_mis++; $display("FAIL reset_mid_outputs: got %h, required 0", all_out); end
      @(negedge clk);
      rst = 1'b1;
      push_expected(1'b0);
      load_job(1'b0, 1'b0, 1'b0);
      finish_job(1'b0, 1'b0);
      n_cmp++;
      if (g_done != 1) begin n_mis++; $display("FAIL reset_mid_done: got %0d cycles, required 1", g_done); end
   endtask

   task automatic test_dims;
      int q [$];
      int wq [$];
      int cyc = 0;
      int comp = 0;
      int idx = 0;
      int ev;
      bit seen_done = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 4; k++) q.push_back(k*3 + j);
            wq.push_back(i*3 + j);
         end
      @(negedge clk);
      d2_start = 1'b1;
      @(negedge clk);
      d2_start = 1'b0;
      d2_in_valid = 1'b1;
      while (idx < 20 && cyc < 200) begin
         if (d2_in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      d2_in_valid = 1'b0;
      while (!d2_out_valid && cyc < 2000) begin
         comp++;
         if (d2_mB_en && !d2_mB_we) begin
            ev = (q.size() > 0) ? q.pop_front() : -1;
            n_cmp++;
            if (int'(d2_mB_addr) !== ev) begin n_mis++; $display("FAIL dims_mB_addr: got %0d, required %0d", d2_mB_addr, ev); end
         end
         if (d2_mC_we) begin
            ev = (wq.size() > 0) ? wq.pop_front() : -1;
            n_cmp++;
            if (int'(d2_mC_addr) !== ev) begin n_mis++; $display("FAIL dims_mC_addr: got %0d, required %0d", d2_mC_addr, ev); end
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (comp - 1 != 54) begin n_mis++; $display("FAIL dims_compute: got %0d, required 54", comp - 1); end
      n_cmp++;
      if (q.size() + wq.size() != 0) begin n_mis++; $display("FAIL dims_addr_left: got %0d, required 0", q.size() + wq.size()); end
      d2_out_ready = 1'b1;
      while (!seen_done && cyc < 3000) begin
         if (d2_done) seen_done = 1'b1;
         @(negedge clk);
         cyc++;
      end
      d2_out_ready = 1'b0;
      n_cmp++;
      if (!seen_done) begin n_mis++; $display("FAIL dims_done: got 0, required 1"); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_accumulate();
      test_stall_hold();
      test_start_ignored();
      test_reset_mid();
      test_dims();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
